// File: rtl/player_controller.sv
// Per-player fighter FSM: buttons and opponent hits in, action state,
// health, position and attack-active flag out; one clock is one frame.
module player_controller #(
    parameter int unsigned MAX_HEALTH   = 5,
    parameter int unsigned WINDUP       = 4,
    parameter int unsigned ACTIVE       = 3,
    parameter int unsigned RECOVER      = 8,
    parameter int unsigned HITSTUN      = 10,
    parameter int unsigned START_X      = 100,
    parameter int unsigned X_MIN        = 0,
    parameter int unsigned X_MAX        = 600,
    parameter int unsigned SPEED        = 2,
    parameter bit          FACING_RIGHT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] game_state,
    input  logic       btn_fwd,
    input  logic       btn_back,
    input  logic       btn_atk,
    input  logic       btn_block,
    input  logic       hit_in,
    output logic [3:0] player_state,
    output logic [2:0] player_health,
    output logic [9:0] pos_x,
    output logic       attack_active
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FWD     = 4'd1,
        S_BACK    = 4'd2,
        S_WINDUP  = 4'd3,
        S_ACTIVE  = 4'd4,
        S_RECOVER = 4'd5,
        S_BLOCK   = 4'd6,
        S_HITSTUN = 4'd7,
        S_DEAD    = 4'd8
    } state_e;

    localparam logic [7:0] WIND_LD = 8'(WINDUP - 1);
    localparam logic [7:0] ACT_LD  = 8'(ACTIVE - 1);
    localparam logic [7:0] REC_LD  = 8'(RECOVER - 1);
    localparam logic [7:0] HIT_LD  = 8'(HITSTUN - 1);

    localparam logic signed [11:0] STEP   = 12'(SPEED);
    localparam logic signed [11:0] XMIN_S = 12'(X_MIN);
    localparam logic signed [11:0] XMAX_S = 12'(X_MAX);

    state_e      state_q, state_d, btn_state;
    logic [2:0]  health_q, health_d;
    logic [9:0]  pos_q, pos_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        act_q, act_d;
    logic        move_plus;
    logic signed [11:0] x_ext;

    always_comb begin
        btn_state = S_IDLE;
        if (btn_atk)
            btn_state = S_WINDUP;
        else if (btn_block)
            btn_state = S_BLOCK;
        else if (btn_fwd ^ btn_back)
            btn_state = btn_fwd ? S_FWD : S_BACK;
    end

    always_comb begin
        state_d   = state_q;
        health_d  = health_q;
        pos_d     = pos_q;
        cnt_d     = cnt_q;
        move_plus = 1'b0;
        x_ext     = '0;

        if (game_state == 3'd0 || game_state == 3'd1) begin
            state_d  = S_IDLE;
            health_d = 3'(MAX_HEALTH);
            pos_d    = 10'(START_X);
            cnt_d    = 8'd0;
        end else if (game_state == 3'd2) begin
            if (hit_in && !(state_q inside {S_BLOCK, S_HITSTUN, S_DEAD})) begin
                health_d = (health_q == 3'd0) ? 3'd0 : health_q - 3'd1;
                if (health_d == 3'd0) begin
                    state_d = S_DEAD;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = S_HITSTUN;
                    cnt_d   = HIT_LD;
                end
            end else begin
                case (state_q)
                    S_IDLE, S_FWD, S_BACK, S_BLOCK: begin
                        state_d = btn_state;
                        cnt_d   = (btn_state == S_WINDUP) ? WIND_LD : 8'd0;
                    end
                    S_WINDUP:
                        if (cnt_q == 8'd0) begin
                            state_d = S_ACTIVE;
                            cnt_d   = ACT_LD;
                        end else cnt_d = cnt_q - 8'd1;
                    S_ACTIVE:
                        if (cnt_q == 8'd0) begin
                            state_d = S_RECOVER;
                            cnt_d   = REC_LD;
                        end else cnt_d = cnt_q - 8'd1;
                    S_RECOVER, S_HITSTUN:
                        if (cnt_q == 8'd0) state_d = S_IDLE;
                        else cnt_d = cnt_q - 8'd1;
                    S_DEAD: ;
                    default: begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end
                endcase
            end

            // Signed 12-bit step so walking past either edge clamps, never wraps
            if (state_d == S_FWD || state_d == S_BACK) begin
                move_plus = ((state_d == S_FWD) == FACING_RIGHT);
                x_ext = $signed({2'b00, pos_q}) + (move_plus ? STEP : -STEP);
                if (x_ext < XMIN_S)
                    pos_d = 10'(XMIN_S);
                else if (x_ext > XMAX_S)
                    pos_d = 10'(XMAX_S);
                else
                    pos_d = 10'(x_ext);
            end
        end

        act_d = (state_d == S_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            health_q <= 3'(MAX_HEALTH);
            pos_q    <= 10'(START_X);
            cnt_q    <= 8'd0;
            act_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            health_q <= health_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            act_q    <= act_d;
        end
    end

    assign player_state  = state_q;
    assign player_health = health_q;
    assign pos_x         = pos_q;
    assign attack_active = act_q;

endmodule

// File: tb/tb_player_controller.sv
// Bench for player_controller: directed frame scenarios plus a randomized
// run checked against a frame-level behavioural model.
module tb_player_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] game_state = 3'd0;
    logic       btn_fwd = 1'b0, btn_back = 1'b0;
    logic       btn_atk = 1'b0, btn_block = 1'b0;
    logic       hit_in = 1'b0;
    logic [3:0] player_state;
    logic [2:0] player_health;
    logic [9:0] pos_x;
    logic       attack_active;

    int vectors = 0;
    int miscompares = 0;

    // Model: state number, frames left in a timed state, health, position
    int m_st = 0, m_left = 0, m_hp = 5, m_x = 100;

    player_controller dut (
        .clk(clk), .reset(reset), .game_state(game_state),
        .btn_fwd(btn_fwd), .btn_back(btn_back),
        .btn_atk(btn_atk), .btn_block(btn_block), .hit_in(hit_in),
        .player_state(player_state), .player_health(player_health),
        .pos_x(pos_x), .attack_active(attack_active)
    );

    always #5 clk = ~clk;

    function automatic void model_frame(input logic r, input logic [2:0] gs,
                                        input logic f, input logic b,
                                        input logic a, input logic bl,
                                        input logic h);
        if (r || gs <= 3'd1) begin
            m_st = 0; m_left = 0; m_hp = 5; m_x = 100;
            return;
        end
        if (gs != 3'd2) return;
        if (h && m_st != 6 && m_st != 7 && m_st != 8) begin
            m_hp = (m_hp > 0) ? m_hp - 1 : 0;
            if (m_hp == 0) m_st = 8;
            else begin m_st = 7; m_left = 10; end
            return;
        end
        case (m_st)
            0, 1, 2, 6: begin
                if (a) begin m_st = 3; m_left = 4; end
                else if (bl) m_st = 6;
                else if (f && !b) m_st = 1;
                else if (b && !f) m_st = 2;
                else m_st = 0;
            end
            3: begin m_left--; if (m_left == 0) begin m_st = 4; m_left = 3; end end
            4: begin m_left--; if (m_left == 0) begin m_st = 5; m_left = 8; end end
            5, 7: begin m_left--; if (m_left == 0) m_st = 0; end
            default: ;
        endcase
        if (m_st == 1) m_x = (m_x + 2 > 600) ? 600 : m_x + 2;
        if (m_st == 2) m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
    endfunction

    task automatic step(input logic r, input logic [2:0] gs, input logic f,
                        input logic b, input logic a, input logic bl,
                        input logic h);
        reset = r; game_state = gs;
        btn_fwd = f; btn_back = b; btn_atk = a; btn_block = bl; hit_in = h;
        @(posedge clk);
        #1;
        model_frame(r, gs, f, b, a, bl, h);
    endtask

    task automatic test_reset();
        step(1, 2, 1, 0, 1, 0, 1);
        step(1, 2, 0, 0, 0, 0, 0);
        vectors++;
        if (player_state !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state got %0d want 0", player_state);
        end
        vectors++;
        if (player_health !== 3'd5) begin
            miscompares++;
            $display("FAIL reset_health got %0d want 5", player_health);
        end
        vectors++;
        if (pos_x !== 10'd100) begin
            miscompares++;
            $display("FAIL reset_pos got %0d want 100", pos_x);
        end
        vectors++;
        if (attack_active !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_active got %0b want 0", attack_active);
        end
    endtask

    task automatic test_walk();
        for (int i = 0; i < 10; i++) step(0, 2, 1, 0, 0, 0, 0);
        vectors++;
        if (player_state !== 4'd1 || pos_x !== 10'd120) begin
            miscompares++;
            $display("FAIL walk_fwd got st=%0d x=%0d want st=1 x=120",
                     player_state, pos_x);
        end
        step(0, 2, 0, 0, 0, 0, 0);
        vectors++;
        if (player_state !== 4'd0 || pos_x !== 10'd120) begin
            miscompares++;
            $display("FAIL walk_release got st=%0d x=%0d want st=0 x=120",
                     player_state, pos_x);
        end
        step(0, 2, 1, 1, 0, 0, 0);
        vectors++;
        if (player_state !== 4'd0 || pos_x !== 10'd120) begin
            miscompares++;
            $display("FAIL walk_both got st=%0d x=%0d want st=0 x=120",
                     player_state, pos_x);
        end
    endtask

    task automatic test_clamp();
        int worst;
        worst = 0;
        for (int i = 0; i < 70; i++) begin
            step(0, 2, 0, 1, 0, 0, 0);
            if (int'(pos_x) > worst && i > 0) worst = int'(pos_x);
        end
        vectors++;
        if (pos_x !== 10'd0 || player_state !== 4'd2 || worst > 120) begin
            miscompares++;
            $display("FAIL clamp_min got x=%0d st=%0d peak=%0d want x=0 st=2",
                     pos_x, player_state, worst);
        end
        for (int i = 0; i < 310; i++) step(0, 2, 1, 0, 0, 0, 0);
        vectors++;
        if (pos_x !== 10'd600) begin
            miscompares++;
            $display("FAIL clamp_max got x=%0d want 600", pos_x);
        end
    endtask

    task automatic test_attack();
        int exp_seq[16] = '{3, 3, 3, 3, 4, 4, 4, 5, 5, 5, 5, 5, 5, 5, 5, 0};
        int act_cnt, bad;
        act_cnt = 0; bad = 0;
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 2, 0, 0, (i == 0), 0, 0);
            if (int'(player_state) != exp_seq[i]) bad++;
            if (attack_active !== (player_state == 4'd4)) bad++;
            if (attack_active === 1'b1) act_cnt++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL attack_seq got %0d bad frames want 0", bad);
        end
        vectors++;
        if (act_cnt != 3) begin
            miscompares++;
            $display("FAIL attack_active_len got %0d want 3", act_cnt);
        end
    endtask

    task automatic test_hit_windup();
        int stun;
        stun = 0;
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 2, 0, 0, 1, 0, 0);
        step(0, 2, 0, 0, 0, 0, 1);
        vectors++;
        if (player_health !== 3'd4 || player_state !== 4'd7) begin
            miscompares++;
            $display("FAIL hit_windup got hp=%0d st=%0d want hp=4 st=7",
                     player_health, player_state);
        end
        stun = 1;
        for (int i = 0; i < 10; i++) begin
            step(0, 2, 1, 0, 1, 0, (i == 3));
            if (player_state === 4'd7) stun++;
        end
        vectors++;
        if (stun != 10 || player_health !== 3'd4) begin
            miscompares++;
            $display("FAIL hitstun got frames=%0d hp=%0d want frames=10 hp=4",
                     stun, player_health);
        end
    endtask

    task automatic test_block_death();
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 2, 0, 0, 0, 1, 0);
        step(0, 2, 0, 0, 0, 1, 1);
        vectors++;
        if (player_health !== 3'd5 || player_state !== 4'd6) begin
            miscompares++;
            $display("FAIL block_hit got hp=%0d st=%0d want hp=5 st=6",
                     player_health, player_state);
        end
        step(0, 2, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 2, 0, 0, 0, 0, 1);
            if (k < 4)
                for (int i = 0; i < 10; i++) step(0, 2, 0, 0, 0, 0, 0);
        end
        vectors++;
        if (player_health !== 3'd0 || player_state !== 4'd8) begin
            miscompares++;
            $display("FAIL death got hp=%0d st=%0d want hp=0 st=8",
                     player_health, player_state);
        end
        for (int i = 0; i < 5; i++) step(0, 2, 1, 0, (i == 2), 0, 1);
        vectors++;
        if (player_state !== 4'd8 || pos_x !== 10'd100 || player_health !== 3'd0) begin
            miscompares++;
            $display("FAIL dead_absorb got st=%0d x=%0d hp=%0d want 8/100/0",
                     player_state, pos_x, player_health);
        end
    endtask

    task automatic test_freeze();
        int bad;
        bad = 0;
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 2, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 2, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, (i < 10) ? 3'd3 : 3'(i % 4 + 4), 1, 0, 1, 0, 1);
            if (player_state !== 4'd7 || player_health !== 3'd4 ||
                pos_x !== 10'd100 || attack_active !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL freeze got %0d moved frames want 0", bad);
        end
        step(0, 0, 1, 0, 1, 0, 1);
        vectors++;
        if (player_state !== 4'd0 || player_health !== 3'd5 || pos_x !== 10'd100) begin
            miscompares++;
            $display("FAIL round_init got st=%0d hp=%0d x=%0d want 0/5/100",
                     player_state, player_health, pos_x);
        end
    endtask

    task automatic test_random();
        logic       r, f, b, a, bl, h;
        logic [2:0] gs;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            gs = ($urandom_range(0, 19) < 17) ? 3'd2 : 3'($urandom_range(0, 7));
            f  = 1'($urandom_range(0, 1));
            b  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) == 0);
            bl = ($urandom_range(0, 5) == 0);
            h  = ($urandom_range(0, 11) == 0);
            step(r, gs, f, b, a, bl, h);
            vectors++;
            if (int'(player_state) != m_st || int'(player_health) != m_hp ||
                int'(pos_x) != m_x || attack_active !== (m_st == 4)) begin
                miscompares++;
                $display("FAIL random n=%0d got st=%0d hp=%0d x=%0d act=%0b want st=%0d hp=%0d x=%0d act=%0b",
                         n, player_state, player_health, pos_x, attack_active,
                         m_st, m_hp, m_x, (m_st == 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_clamp();
        test_attack();
        test_hit_windup();
        test_block_death();
        test_freeze();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
